// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO (depth 2^AW).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int AW           = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          UART_txd,
    output logic          tx_busy,
    output logic [AW:0]   fifo_count
);

    localparam int DEPTH = 1 << AW;
    localparam int BCW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BCW-1:0] BAUD_MAX   = BCW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e         state_q, state_d;
    logic [BCW-1:0] baud_q, baud_d;
    logic [2:0]     bitIdx_q, bitIdx_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    logic [7:0]     mem_q [DEPTH];
    logic [AW-1:0]  wrPtr_q, wrPtr_d;
    logic [AW-1:0]  rdPtr_q, rdPtr_d;
    logic [AW:0]    count_q, count_d;

    logic           push;
    logic           pop;
    logic           baudWrap;
    logic [7:0]     headByte;

    assign tx_ready   = (count_q != FULL_COUNT);
    assign push       = tx_valid && tx_ready;
    assign baudWrap   = (baud_q == BAUD_MAX);
    assign headByte   = mem_q[rdPtr_q];
    assign UART_txd   = txd_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign fifo_count = count_q;

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= tx_data;
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baudWrap ? '0 : baud_q + 1'b1;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = headByte;
                    txd_d   = 1'b0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^headByte;
`endif
                end
            end
            S_START: begin
                if (baudWrap) begin
                    state_d  = S_DATA;
                    bitIdx_d = 3'd0;
                    txd_d    = shift_q[0];
                end
            end
            // The register shifts right so the bit on the line always sits in shift_q[0].
            S_DATA: begin
                if (baudWrap) begin
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                        shift_d  = {1'b0, shift_q[7:1]};
                        txd_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baudWrap) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baudWrap) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = headByte;
                        txd_d   = 1'b0;
                        state_d = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^headByte;
`endif
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at CLKS_PER_BIT=16, AW=2.
// Honours UART_TX_PARITY_EN for 11-bit frames and the extra parity vectors.
module tb_uart_tx_fifo;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       UART_txd;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int compareCount  = 0;
    int mismatchCount = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .AW(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .UART_txd(UART_txd),
        .tx_busy(tx_busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        tx_valid = valid;
        tx_data  = data;
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level at a given clock cycle of a frame (cycle 0 = first start-bit clock).
    function automatic logic expBit(input logic [7:0] data, input int cycle);
        int k;
        k = cycle / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return data[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^data;
`endif
        return 1'b1;
    endfunction

    // Checks frame cycles first..last; tx_valid drops after the first edge.
    task automatic frameCycles(input logic [7:0] data, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            checkOutput($sformatf("txd byte%02h cyc%0d", data, i), 32'(UART_txd), 32'(expBit(data, i)));
            checkOutput($sformatf("busy byte%02h cyc%0d", data, i), 32'(tx_busy), 32'd1);
            tick();
            if (i == first) tx_valid = 1'b0;
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " txd"}, 32'(UART_txd), 32'd1);
        checkOutput({tag, " busy"}, 32'(tx_busy), 32'd0);
        checkOutput({tag, " ready"}, 32'(tx_ready), 32'd1);
        checkOutput({tag, " count"}, 32'(fifo_count), 32'd0);
    endtask

    logic [7:0] fullBytes [6];

    initial begin
        fullBytes[0] = 8'h11; fullBytes[1] = 8'h22; fullBytes[2] = 8'h33;
        fullBytes[3] = 8'h44; fullBytes[4] = 8'h5A; fullBytes[5] = 8'hC3;

        // Reset held for three edges
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00);
        tick(); tick(); tick();
        checkIdle("reset");
        reset = 1'b0;
        tick();
        checkIdle("post-reset");

        // Single byte 0x55
        applyStimulus(1'b1, 8'h55);
        tick();
        checkOutput("single count after push", 32'(fifo_count), 32'd1);
        checkOutput("single txd before start", 32'(UART_txd), 32'd1);
        checkOutput("single busy before start", 32'(tx_busy), 32'd0);
        applyStimulus(1'b0, 8'h00);
        tick();
        frameCycles(8'h55, 0, FRAME - 1);
        checkIdle("single end");

        // Back-to-back 0xA5, 0x3C, 0xFF
        applyStimulus(1'b1, 8'hA5);
        tick();
        applyStimulus(1'b1, 8'h3C);
        tick();
        checkOutput("b2b count after pop", 32'(fifo_count), 32'd1);
        applyStimulus(1'b1, 8'hFF);
        frameCycles(8'hA5, 0, FRAME - 1);
        frameCycles(8'h3C, 0, FRAME - 1);
        frameCycles(8'hFF, 0, FRAME - 1);
        checkIdle("b2b end");

        // Full FIFO: six pushes on consecutive edges, the sixth is refused
        applyStimulus(1'b1, fullBytes[0]);
        tick();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, fullBytes[i]);
            tick();
        end
        checkOutput("full count", 32'(fifo_count), 32'd4);
        checkOutput("full ready", 32'(tx_ready), 32'd0);
        applyStimulus(1'b1, fullBytes[5]);
        frameCycles(fullBytes[0], 3, FRAME - 1);
        checkOutput("full count after 2nd pop", 32'(fifo_count), 32'd3);
        for (int i = 1; i <= 4; i++) begin
            frameCycles(fullBytes[i], 0, FRAME - 1);
        end
        checkIdle("full end");

        // Push on the stop-bit wrap edge while one byte is queued
        applyStimulus(1'b1, 8'h96);
        tick();
        applyStimulus(1'b1, 8'h0F);
        tick();
        applyStimulus(1'b0, 8'h00);
        frameCycles(8'h96, 0, FRAME - 2);
        checkOutput("simul count before wrap", 32'(fifo_count), 32'd1);
        applyStimulus(1'b1, 8'hE1);
        frameCycles(8'h96, FRAME - 1, FRAME - 1);
        checkOutput("simul count after wrap", 32'(fifo_count), 32'd1);
        checkOutput("simul txd start", 32'(UART_txd), 32'd0);
        checkOutput("simul busy", 32'(tx_busy), 32'd1);
        frameCycles(8'h0F, 0, FRAME - 1);
        frameCycles(8'hE1, 0, FRAME - 1);
        checkIdle("simul end");

`ifdef UART_TX_PARITY_EN
        // Parity vectors: 0x07 -> parity 1, 0x03 -> parity 0
        applyStimulus(1'b1, 8'h07);
        tick();
        applyStimulus(1'b0, 8'h00);
        tick();
        frameCycles(8'h07, 0, FRAME - 1);
        checkIdle("parity 07 end");
        applyStimulus(1'b1, 8'h03);
        tick();
        applyStimulus(1'b0, 8'h00);
        tick();
        frameCycles(8'h03, 0, FRAME - 1);
        checkIdle("parity 03 end");
`endif

        // Reset mid-frame with a byte still queued
        applyStimulus(1'b1, 8'h00);
        tick();
        applyStimulus(1'b1, 8'h81);
        tick();
        applyStimulus(1'b0, 8'h00);
        frameCycles(8'h00, 0, 39);
        checkOutput("midreset count before", 32'(fifo_count), 32'd1);
        reset = 1'b1;
        tick();
        checkIdle("midreset");
        reset = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            tick();
        end
        checkIdle("midreset dropped");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
8N1 UART transmitter with a small byte FIFO. It is the transmit counterpart of the processor's UART receive path and drives the top-level UART_txd pin of p_processor. The CPU-side UART peripheral register logic pushes bytes with a valid/ready handshake. The block serialises them LSB-first at a fixed baud rate derived from the system clock (default 50 MHz clock, 9600 baud).

Parameters:
CLKS_PER_BIT, 5208, system clocks per UART bit; 50 MHz / 9600 baud. Legal range ≥ 2.
AW, 2, FIFO address width; depth = 2^AW = 4 entries.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
tx_data  input  8  byte to enqueue.
tx_valid  input  1  enqueue request.
tx_ready  output  1  FIFO not full; a byte is accepted on an edge where tx_valid && tx_ready.
UART_txd  output  1  serial line, registered, idles high.
tx_busy  output  1  high while a frame is on the line (any state other than IDLE).
fifo_count  output  AW+1  number of bytes queued, excluding the byte being shifted.

Behaviour:
- Reset, applied at a clock edge while reset=1, gives: UART_txd=1, tx_busy=0, fifo_count=0, tx_ready=1, state=IDLE, bit counter=0, baud counter=0. FIFO contents are don't-care.
- Reset asserted mid-frame aborts the frame at the next edge and drops all queued bytes. The line returns high immediately, with no stop bit.
- FIFO:
  - Circular buffer with AW-bit read and write pointers plus an (AW+1)-bit count.
  - tx_ready = (fifo_count != 2^AW), combinational from the count.
  - A push and a pop on the same edge leave the count unchanged.
  - When full, tx_ready=0, so a write is refused even if a pop happens on the same edge.
- FSM states: IDLE, START, DATA, STOP (PARITY when enabled).
  - IDLE: UART_txd=1. If fifo_count>0, pop the head into an 8-bit shift register, drive UART_txd=0, go to START, clear the baud counter.
  - START: hold 0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0 and drive shift[0].
  - DATA: each bit is held CLKS_PER_BIT clocks, LSB first. After bit 7's period, go to STOP (or PARITY) and drive 1.
  - STOP: hold 1 for CLKS_PER_BIT clocks. At the end, if fifo_count>0, pop and go straight to START with the line low (back-to-back, no idle gap). Otherwise go to IDLE.
- Timing:
  - A byte written at edge N into an empty FIFO while IDLE drives the start bit from edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT clocks (11 with parity).
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; the state or bit advances on the wrap.
- Line glitches: UART_txd comes straight from a flop and never glitches.
- tx_busy goes high on the edge that leaves IDLE and low on the edge that returns to IDLE.
- Writes during any state are accepted if not full; they never disturb the frame in flight.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits, captured at pop) for CLKS_PER_BIT clocks. Frame = 11 bit periods.
- Undefined: no PARITY state or logic; 10-bit frames as above.

Test Plan:
- Reset: hold reset=1 for 3 edges -> UART_txd=1, tx_busy=0, tx_ready=1, fifo_count=0. Pulse reset mid-frame -> UART_txd=1 on the next edge and fifo_count=0.
- Single byte, CLKS_PER_BIT=16: push 0x55 at edge N -> line 0 from N+1 for 16 clocks, then bits 1,0,1,0,1,0,1,0 for 16 clocks each, then 1 for 16 clocks. tx_busy high for exactly 160 clocks.
- Back-to-back: push 0xA5, 0x3C, 0xFF on consecutive edges -> three frames with no idle between a stop and the next start. Decoded bytes are 0xA5, 0x3C, 0xFF in order.
- Full FIFO, CLKS_PER_BIT=16: push 6 bytes on consecutive edges starting while IDLE -> first byte popped immediately, next 4 fill the FIFO, tx_ready=0. The 6th byte is refused and never appears on the line.
- Simultaneous push and pop: push exactly at the stop-bit wrap edge with fifo_count=1 -> fifo_count stays 1, and the next frame starts on that same edge.
- UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0. Frame length 176 clocks at CLKS_PER_BIT=16.
